// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard/dump signal bundle for the multi-port register file
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1, ra2, wa0, wa1, sb_addr, dump_addr;
    logic [DATA_W-1:0] rd1, rd2, wd0, wd1, dump_data;
    logic              we0, we1, sb_set, pend1, pend2;
    logic              dump_start, dump_ready, dump_valid, dump_busy, dump_done;

    modport master (
        output ra1, ra2, we0, we1, wa0, wa1, wd0, wd1, sb_set, sb_addr, dump_start, dump_ready,
        input  rd1, rd2, pend1, pend2, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  ra1, ra2, we0, we1, wa0, wa1, wd0, wd1, sb_set, sb_addr, dump_start, dump_ready,
        output rd1, rd2, pend1, pend2, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with write bypass, pending scoreboard and serial dump engine
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    state_t            state_q;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0] dump_data_q, dump_rd;
    logic              dump_valid_q, dump_busy_q, dump_done_q;
    logic              eff0, eff1;

    // Effective writes: address-0 writes are dropped entirely when register 0 is hardwired
    always_comb begin
        eff0 = bus.we0 && !(ZERO_REG != 0 && bus.wa0 == '0);
        eff1 = bus.we1 && !(ZERO_REG != 0 && bus.wa1 == '0);
    end

    // Bypassed reads: port 1 data beats port 0 data beats the stored value
    always_comb begin
        bus.rd1 = (ZERO_REG != 0 && bus.ra1 == '0) ? '0 :
                  (eff1 && bus.wa1 == bus.ra1) ? bus.wd1 :
                  (eff0 && bus.wa0 == bus.ra1) ? bus.wd0 : regs_q[bus.ra1];
        bus.rd2 = (ZERO_REG != 0 && bus.ra2 == '0) ? '0 :
                  (eff1 && bus.wa1 == bus.ra2) ? bus.wd1 :
                  (eff0 && bus.wa0 == bus.ra2) ? bus.wd0 : regs_q[bus.ra2];
        dump_rd = (ZERO_REG != 0 && dump_addr_q == '0) ? '0 :
                  (eff1 && bus.wa1 == dump_addr_q) ? bus.wd1 :
                  (eff0 && bus.wa0 == dump_addr_q) ? bus.wd0 : regs_q[dump_addr_q];
    end

    // Register array; port 1 is assigned last so it wins on an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            if (eff0) regs_q[bus.wa0] <= bus.wd0;
            if (eff1) regs_q[bus.wa1] <= bus.wd1;
        end
    end

    // Scoreboard next state: writes clear, a same-cycle set overrides the clear
    always_comb begin
        pend_d = pend_q;
        if (eff0) pend_d[bus.wa0] = 1'b0;
        if (eff1) pend_d[bus.wa1] = 1'b0;
        if (bus.sb_set) pend_d[bus.sb_addr] = 1'b1;
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign bus.pend1 = pend_q[bus.ra1];
    assign bus.pend2 = pend_q[bus.ra2];

    // Dump engine: capture one register in LOAD, hold it in SEND until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.dump_start) begin
                    state_q     <= LOAD;
                    dump_addr_q <= '0;
                    dump_busy_q <= 1'b1;
                end
                LOAD: begin
                    state_q      <= SEND;
                    dump_data_q  <= dump_rd;
                    dump_valid_q <= 1'b1;
                end
                SEND: if (bus.dump_ready) begin
                    dump_valid_q <= 1'b0;
                    if (dump_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= DONE;
                        dump_done_q <= 1'b1;
                    end else begin
                        state_q     <= LOAD;
                        dump_addr_q <= dump_addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    dump_addr_q <= '0;
                    dump_busy_q <= 1'b0;
                    dump_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_busy  = dump_busy_q;
    assign bus.dump_done  = dump_done_q;
endmodule
